// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx
// Serial-to-parallel receiver. It hunts the 1-bit stream for the comma symbol
// at any bit offset and confirms byte alignment with a run of aligned commas.
// Once locked, it delivers one byte per 8 clocks, each tagged as data or idle.
// The lock is held until reset; there is no loss-of-lock detection.
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       IDLE_OUT,
    output logic       active,
    output logic       byte_strobe
);

    // The lock threshold is held in the same 4-bit width as the comma counter.
    localparam logic [3:0] LOCK_COUNT_S = 4'(LOCK_COUNT);
    localparam logic       LOCK_ONE_S   = (LOCK_COUNT == 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_SYNCING  = 2'b01,
        ST_LOCKED   = 2'b10
    } state_t;

    // Compares a candidate byte against the alignment symbol.
    function automatic logic is_comma(input logic [7:0] b);
        return (b == COMMA);
    endfunction

    // Steps the comma counter up by one and saturates at its maximum.
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        if (c == 4'hF) begin
            return 4'hF;
        end else begin
            return c + 4'd1;
        end
    endfunction

    state_t      state_r;
    state_t      state_next_s;

    // Only the seven most recent bits are kept. The incoming bit supplies the
    // eighth bit of every candidate byte.
    logic [6:0]  sr_r;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_cnt_next_s;
    logic [3:0]  bc_cnt_r;
    logic [3:0]  bc_cnt_next_s;
    logic [3:0]  bc_inc_s;
    logic [7:0]  data_r;
    logic [7:0]  data_next_s;
    logic        valid_r;
    logic        valid_next_s;
    logic        idle_r;
    logic        idle_next_s;
    logic        active_r;
    logic        active_next_s;
    logic        strobe_r;
    logic        strobe_next_s;

    logic [7:0]  cand_s;
    logic        cand_comma_s;
    logic        boundary_s;

    assign cand_s       = {sr_r, data_in};
    assign cand_comma_s = is_comma(cand_s);
    assign boundary_s   = (bit_cnt_r == 3'd7);
    assign bc_inc_s     = sat_inc(bc_cnt_r);

    // Next-state and next-output logic for the alignment FSM.
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        bc_cnt_next_s  = bc_cnt_r;
        data_next_s    = data_r;
        valid_next_s   = valid_r;
        idle_next_s    = idle_r;
        active_next_s  = active_r;
        strobe_next_s  = 1'b0;

        case (state_r)
            ST_UNLOCKED: begin
                // Free-running hunt. A match at any bit offset defines the byte phase.
                bit_cnt_next_s = 3'd0;
                if (cand_comma_s) begin
                    bc_cnt_next_s = 4'd1;
                    if (LOCK_ONE_S) begin
                        state_next_s  = ST_LOCKED;
                        active_next_s = 1'b1;
                    end else begin
                        state_next_s  = ST_SYNCING;
                    end
                end else begin
                    bc_cnt_next_s = 4'd0;
                end
            end

            ST_SYNCING: begin
                bit_cnt_next_s = bit_cnt_r + 3'd1;
                if (boundary_s) begin
                    if (cand_comma_s) begin
                        bc_cnt_next_s = bc_inc_s;
                        if (bc_inc_s == LOCK_COUNT_S) begin
                            state_next_s  = ST_LOCKED;
                            active_next_s = 1'b1;
                        end else begin
                            state_next_s  = ST_SYNCING;
                        end
                    end else begin
                        // A misaligned or corrupted byte restarts the hunt.
                        // The bits already shifted in stay in use.
                        state_next_s  = ST_UNLOCKED;
                        bc_cnt_next_s = 4'd0;
                    end
                end else begin
                    bc_cnt_next_s = bc_cnt_r;
                end
            end

            ST_LOCKED: begin
                bit_cnt_next_s = bit_cnt_r + 3'd1;
                if (boundary_s) begin
                    strobe_next_s = 1'b1;
                    if (cand_comma_s) begin
                        // An idle byte keeps the last data byte visible.
                        valid_next_s = 1'b0;
                        idle_next_s  = 1'b1;
                    end else begin
                        data_next_s  = cand_s;
                        valid_next_s = 1'b1;
                        idle_next_s  = 1'b0;
                    end
                end else begin
                    strobe_next_s = 1'b0;
                end
            end

            default: begin
                // An illegal encoding falls back to a clean hunt.
                state_next_s   = ST_UNLOCKED;
                bit_cnt_next_s = 3'd0;
                bc_cnt_next_s  = 4'd0;
                data_next_s    = 8'h00;
                valid_next_s   = 1'b0;
                idle_next_s    = 1'b0;
                active_next_s  = 1'b0;
            end
        endcase
    end

    // State, shift register and output registers. The reset is synchronous and has the highest priority.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_r   <= ST_UNLOCKED;
            sr_r      <= 7'd0;
            bit_cnt_r <= 3'd0;
            bc_cnt_r  <= 4'd0;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            idle_r    <= 1'b0;
            active_r  <= 1'b0;
            strobe_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            sr_r      <= cand_s[6:0];
            bit_cnt_r <= bit_cnt_next_s;
            bc_cnt_r  <= bc_cnt_next_s;
            data_r    <= data_next_s;
            valid_r   <= valid_next_s;
            idle_r    <= idle_next_s;
            active_r  <= active_next_s;
            strobe_r  <= strobe_next_s;
        end
    end

    assign data_out    = data_r;
    assign valid_out   = valid_r;
    assign IDLE_OUT    = idle_r;
    assign active      = active_r;
    assign byte_strobe = strobe_r;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx
// Directed bench for the serial receiver. A cycle-level behavioural model
// tracks the bit window and the cycle number of the next expected byte
// boundary. It is compared with the DUT on every falling edge. Literal
// expectations for each scenario pin both the model and the DUT.
module tb_serial_paralelo_rx;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         LOCK  = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       IDLE_OUT;
    logic       active;
    logic       byte_strobe;

    int vectors     = 0;
    int miscompares = 0;

    serial_paralelo_rx #(.COMMA(COMMA), .LOCK_COUNT(LOCK)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .IDLE_OUT   (IDLE_OUT),
        .active     (active),
        .byte_strobe(byte_strobe)
    );

    // 10-unit bit clock
    always #5 clk_32f = ~clk_32f;

    // ---------------- behavioural model ----------------
    bit         m_ready  = 1'b0;
    logic [7:0] m_win    = 8'h00;
    int         m_mode   = 0;     // 0 hunting, 1 confirming, 2 locked
    int         m_commas = 0;
    int         m_next   = 0;     // cycle number of the next byte boundary
    int         m_cyc    = 0;
    logic [7:0] e_data   = 8'h00;
    logic       e_valid  = 1'b0;
    logic       e_idle   = 1'b0;
    logic       e_active = 1'b0;
    logic       e_strobe = 1'b0;

    // model update on every rising edge
    initial begin
        logic [7:0] cand;
        forever begin
            @(posedge clk_32f);
            m_cyc++;
            if (reset) begin
                m_win = 8'h00; m_mode = 0; m_commas = 0; m_next = 0;
                e_data = 8'h00; e_valid = 1'b0; e_idle = 1'b0;
                e_active = 1'b0; e_strobe = 1'b0;
                m_ready = 1'b1;
            end else begin
                cand     = {m_win[6:0], data_in};
                m_win    = cand;
                e_strobe = 1'b0;
                if (m_mode == 2) begin
                    if (m_cyc == m_next) begin
                        e_strobe = 1'b1;
                        m_next   = m_cyc + 8;
                        if (cand == COMMA) begin
                            e_valid = 1'b0; e_idle = 1'b1;
                        end else begin
                            e_data = cand; e_valid = 1'b1; e_idle = 1'b0;
                        end
                    end
                end else if (m_mode == 1) begin
                    if (m_cyc == m_next) begin
                        if (cand == COMMA) begin
                            m_commas++;
                            m_next = m_cyc + 8;
                            if (m_commas >= LOCK) begin
                                m_mode = 2; e_active = 1'b1;
                            end
                        end else begin
                            m_mode = 0; m_commas = 0;
                        end
                    end
                end else begin
                    if (cand == COMMA) begin
                        m_commas = 1;
                        m_next   = m_cyc + 8;
                        if (LOCK == 1) begin
                            m_mode = 2; e_active = 1'b1;
                        end else begin
                            m_mode = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- compare process and strobe log ----------------
    logic [9:0] log_q[$];
    int         scyc_q[$];
    int         ncyc      = 0;
    int         rise_cyc  = -1;
    logic       prev_act  = 1'b0;

    initial begin
        forever begin
            @(negedge clk_32f);
            ncyc++;
            if (m_ready) begin
                vectors++;
                if ({data_out, valid_out, IDLE_OUT, active, byte_strobe} !==
                    {e_data, e_valid, e_idle, e_active, e_strobe}) begin
                    miscompares++;
                    $display("FAIL cycle_compare @%0d: got data=%h v=%b i=%b a=%b s=%b want data=%h v=%b i=%b a=%b s=%b",
                             ncyc, data_out, valid_out, IDLE_OUT, active, byte_strobe,
                             e_data, e_valid, e_idle, e_active, e_strobe);
                end
                if (byte_strobe === 1'b1) begin
                    log_q.push_back({data_out, valid_out, IDLE_OUT});
                    scyc_q.push_back(ncyc);
                end
                if (active === 1'b1 && prev_act !== 1'b1) rise_cyc = ncyc;
                prev_act = active;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    function automatic int entry(input int i);
        if (i < log_q.size()) return int'(log_q[i]);
        else return -1;
    endfunction

    function automatic int gap(input int i);
        if (i < scyc_q.size()) begin
            if (i == 0) return scyc_q[0] - rise_cyc;
            else return scyc_q[i] - scyc_q[i-1];
        end else begin
            return -1;
        end
    endfunction

    function automatic int ent(input logic [7:0] d, input logic v, input logic i);
        logic [9:0] e;
        e = {d, v, i};
        return int'(e);
    endfunction

    task automatic send_bit(input logic b);
        data_in = b;
        reset   = 1'b0;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (n) @(posedge clk_32f);
        #1;
        reset = 1'b0;
        log_q.delete();
        scyc_q.delete();
        rise_cyc = -1;
    endtask

    task automatic flush();
        @(negedge clk_32f);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // 1: long run of zeros never locks
        do_reset(2);
        check("reset_data", int'(data_out), 0);
        check("reset_active", int'(active), 0);
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        flush();
        check("zeros_strobes", log_q.size(), 0);
        check("zeros_active", int'(active), 0);
        check("zeros_outputs", int'({data_out, valid_out, IDLE_OUT}), 0);

        // 2: three idle bits, four commas, then 5A and 3C
        do_reset(1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("active_after_3rd_comma", int'(active), 0);
        send_byte(8'hBC);
        check("active_after_4th_comma", int'(active), 1);
        send_byte(8'h5A);
        send_byte(8'h3C);
        flush();
        check("lock_strobe_count", log_q.size(), 2);
        check("lock_byte0", entry(0), ent(8'h5A, 1'b1, 1'b0));
        check("lock_byte1", entry(1), ent(8'h3C, 1'b1, 1'b0));
        check("first_strobe_delay", gap(0), 8);
        check("second_strobe_gap", gap(1), 8);

        // 3: data, idle, data while locked
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'h11);
        send_byte(8'hBC);
        send_byte(8'h22);
        flush();
        check("idle_strobe_count", log_q.size(), 3);
        check("idle_byte0", entry(0), ent(8'h11, 1'b1, 1'b0));
        check("idle_byte1", entry(1), ent(8'h11, 1'b0, 1'b1));
        check("idle_byte2", entry(2), ent(8'h22, 1'b1, 1'b0));

        // 4: broken comma run restarts the hunt
        do_reset(1);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h77);
        check("break_not_active", int'(active), 0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("break_3_commas", int'(active), 0);
        send_byte(8'hBC);
        check("break_relocked", int'(active), 1);
        send_byte(8'hA5);
        flush();
        check("break_strobe_count", log_q.size(), 1);
        check("break_byte0", entry(0), ent(8'hA5, 1'b1, 1'b0));

        // 5: reset in the middle of a byte while locked
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'h5A);
        check("pre_reset_data", int'(data_out), 8'h5A);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        do_reset(1);
        check("midreset_outputs",
              int'({data_out, valid_out, IDLE_OUT, active, byte_strobe}), 0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("relock_3_commas", int'(active), 0);
        send_byte(8'hBC);
        check("relock_4_commas", int'(active), 1);
        send_byte(8'h66);
        flush();
        check("relock_byte0", entry(0), ent(8'h66, 1'b1, 1'b0));

        // 6: all-ones and all-zeros data bytes
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'hFF);
        send_byte(8'h00);
        flush();
        check("ff00_strobe_count", log_q.size(), 2);
        check("ff00_byte0", entry(0), ent(8'hFF, 1'b1, 1'b0));
        check("ff00_byte1", entry(1), ent(8'h00, 1'b1, 1'b0));
        check("ff00_gap0", gap(0), 8);
        check("ff00_gap1", gap(1), 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Receive-side counterpart of the parallel-to-serial transmitter. It takes the 1-bit serial stream produced at clk_32f and acquires byte alignment by hunting for the comma/idle symbol 0xBC. After a run of consecutive commas it declares the link active. It then deserializes the stream into bytes, each marked as data (valid) or idle. It feeds the downstream byte-to-lane demultiplexer; lane distribution is out of scope.

Parameters:
COMMA, 8'hBC, alignment/idle symbol; the transmitter emits it when no lane data is valid.
LOCK_COUNT, 4, consecutive aligned commas required to enter LOCKED (legal range 1..15).

Ports:
clk_32f  input  1  serial bit clock, rising-edge only
reset  input  1  synchronous, active-high; sampled on the rising edge of clk_32f
data_in  input  1  serial data from the transmitter, MSB first, one bit per clk_32f cycle
data_out  output  8  last received data byte
valid_out  output  1  high when data_out was updated by a non-comma byte at the last strobe
IDLE_OUT  output  1  high when the last byte received in LOCKED was COMMA
active  output  1  link locked and delivering bytes
byte_strobe  output  1  one-cycle pulse marking each byte boundary while LOCKED

Behaviour:
- All state and outputs are registered on the rising edge of clk_32f; no combinational input-to-output paths.
- Reset (synchronous, highest priority, may occur mid-byte or mid-lock):
  - sr=0, bit_cnt=0, bc_cnt=0, state=UNLOCKED.
  - data_out=0, valid_out=0, IDLE_OUT=0, active=0, byte_strobe=0.
- Shift register: sr <= {sr[6:0], data_in} every non-reset cycle. Define cand = {sr[6:0], data_in}, the byte completed by the current bit.
- UNLOCKED:
  - Compare cand against COMMA on every cycle, at any bit offset.
  - On a match: bc_cnt<=1, bit_cnt<=0, state<=SYNCING. If LOCK_COUNT==1, go directly to LOCKED and set active<=1.
- SYNCING:
  - bit_cnt increments mod 8. A byte boundary is the cycle with bit_cnt==7.
  - At a boundary with cand==COMMA: bc_cnt<=bc_cnt+1. When the new count equals LOCK_COUNT: state<=LOCKED, active<=1, bit_cnt wraps to 0.
  - At a boundary with cand!=COMMA: state<=UNLOCKED, bc_cnt<=0.
  - No byte_strobe is produced during SYNCING.
- LOCKED (held until reset; there is no loss-of-lock detection):
  - bit_cnt increments mod 8. At each boundary (bit_cnt==7), in the same edge: byte_strobe<=1.
  - If cand==COMMA: valid_out<=0, IDLE_OUT<=1, data_out holds its previous value.
  - Otherwise: data_out<=cand, valid_out<=1, IDLE_OUT<=0.
  - At non-boundary cycles: byte_strobe<=0. valid_out, IDLE_OUT and data_out hold.
- Latency: outputs update on the same edge that samples the last bit (LSB) of the byte, so they are visible one edge after the final bit is presented.
- The comma that completes the lock does not produce a strobe. The first strobe is for the following byte, exactly 8 cycles after active rises.
- bc_cnt is 4 bits and saturates; it never wraps.
- A bit-slipped comma in SYNCING counts as a non-comma and restarts the hunt. Bits already in sr are reused, so the hunt can re-match on the very next cycle.

Test Plan:
- Reset then 40 cycles of data_in=0 -> active=0, byte_strobe never pulses, all outputs 0.
- 3 idle bits, then 4×0xBC, then 0x5A, 0x3C -> active rises on the edge sampling the LSB of the 4th 0xBC. Strobes follow 8 and 16 cycles later, with data_out=0x5A then 0x3C and valid_out=1, IDLE_OUT=0.
- Locked stream 0x11, 0xBC, 0x22 -> strobe 1: data_out=0x11, valid=1. Strobe 2: data_out stays 0x11, valid=0, IDLE_OUT=1. Strobe 3: data_out=0x22, valid=1, IDLE_OUT=0.
- 0xBC, 0xBC, 0x77, then 4×0xBC, 0xA5 -> returns to UNLOCKED at the 0x77 boundary. Locks only after the subsequent 4 commas; the first strobe delivers 0xA5.
- Locked, then reset asserted for 1 cycle at bit 3 of a byte -> on the next edge all outputs are 0 and active=0. Relock requires 4 fresh commas.
- Locked, with consecutive bytes 0xFF and 0x00 -> strobes exactly every 8 cycles, data_out=0xFF then 0x00, valid_out=1 throughout.
